// File: rtl/sys_pll_sup_pkg.sv
// Shared types and helpers for the system PLL lock supervisor.
// Holds the supervisor state encoding and the timer width calculation.
package sys_pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    // Width of a counter that must hold 0 .. max(a,b,c)-1.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sys_pll_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Both stages reset to 0 so a lock indication is never assumed after reset.
module sys_pll_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture the asynchronous input, then re-register to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/sys_pll_lock_supervisor.sv
// PLL reset / lock supervisor on the reference clock; releases the downstream reset.
// Optional build macro SYS_PLL_LOCK_GLITCH_FILTER_EN filters short lock dips while in RUN.
module sys_pll_lock_supervisor
    import sys_pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             pll_locked,
    input  logic                             clear_fault,
    output logic                             pll_rst,
    output logic                             sys_reset_n,
    output logic                             running,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [CNT_W-1:0]                 loss_count
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0]    RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX     = {CNT_W{1'b1}};

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
        MAX_RETRIES < 1 || CNT_W < 1 || GLITCH_CYCLES < 1) begin : g_param_check
        $error("sys_pll_lock_supervisor: cycle and width parameters must be >= 1");
    end

    sup_state_t     state_r;
    logic [TW-1:0]  timer_r;
    logic [RW-1:0]  retry_next_s;
    logic           lk_s;
    logic           loss_s;

    sys_pll_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    assign retry_next_s = retry_count + RW'(1);

`ifdef SYS_PLL_LOCK_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

    logic [GW-1:0] glitch_r;

    assign loss_s = !lk_s && (glitch_r == GLITCH_LAST);

    // Count consecutive low lock samples in RUN; any high sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_r <= '0;
        end else if (state_r != RUN || lk_s || loss_s) begin
            glitch_r <= '0;
        end else begin
            glitch_r <= glitch_r + GW'(1);
        end
    end
`else
    assign loss_s = !lk_s;
`endif

    // Supervisor FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= PLL_RESET;
            timer_r     <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            running     <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            case (state_r)
                // Counts up from 0 so the reset value of the timer gives a full first pulse.
                PLL_RESET: begin
                    if (timer_r == RST_LAST) begin
                        state_r <= WAIT_LOCK;
                        timer_r <= TIMEOUT_LAST;
                        pll_rst <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_r <= STABLE;
                        timer_r <= STABLE_LAST;
                    end else if (timer_r == '0) begin
                        pll_rst     <= 1'b1;
                        retry_count <= retry_next_s;
                        if (retry_next_s == RETRY_MAX) begin
                            state_r <= FAULT;
                            fault   <= 1'b1;
                        end else begin
                            state_r <= PLL_RESET;
                        end
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state_r <= WAIT_LOCK;
                        timer_r <= TIMEOUT_LAST;
                    end else if (timer_r == '0) begin
                        state_r     <= RUN;
                        sys_reset_n <= 1'b1;
                        running     <= 1'b1;
                        retry_count <= '0;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                RUN: begin
                    if (loss_s) begin
                        state_r     <= PLL_RESET;
                        timer_r     <= '0;
                        pll_rst     <= 1'b1;
                        sys_reset_n <= 1'b0;
                        running     <= 1'b0;
                        if (loss_count != LOSS_MAX) begin
                            loss_count <= loss_count + CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        state_r     <= PLL_RESET;
                        timer_r     <= '0;
                        fault       <= 1'b0;
                        retry_count <= '0;
                    end
                end
                default: begin
                    state_r     <= PLL_RESET;
                    timer_r     <= '0;
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                    running     <= 1'b0;
                    fault       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues expected output snapshots with the cycle they must appear;
// a monitor compares every change of the registered output set against the queue.
module tb_sys_pll_lock_supervisor;

    localparam int R  = 4;
    localparam int LT = 50;
    localparam int S  = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       clear_fault;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       running;
    logic       fault;
    logic [2:0] retry_count;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          exp_cyc[$];
    logic [14:0] exp_val[$];

    sys_pll_lock_supervisor #(
        .RST_CYCLES    (R),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (S),
        .MAX_RETRIES   (4),
        .CNT_W         (8),
        .GLITCH_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .clear_fault (clear_fault),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .running     (running),
        .fault       (fault),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] tup(input bit pr, input bit sr, input bit rn,
                                        input bit ft, input int rc, input int lc);
        return {pr, sr, rn, ft, 3'(rc), 8'(lc)};
    endfunction

    task automatic expect_at(input int c, input logic [14:0] v);
        exp_cyc.push_back(c);
        exp_val.push_back(v);
    endtask

    // Advance to just after negedge n (inputs then settle well before posedge n+1).
    task automatic to_neg(input int n);
        do @(negedge clk); while (cyc < n);
        #1;
    endtask

    // Monitor: any change of the output set must match the head of the queue.
    initial begin
        logic [14:0] prev;
        logic [14:0] snap;
        logic [14:0] ev;
        int          ec;
        prev = 'x;
        forever begin
            @(negedge clk);
            snap = {pll_rst, sys_reset_n, running, fault, retry_count, loss_count};
            if (snap !== prev) begin
                checks++;
                if (exp_val.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, snap);
                end else begin
                    ev = exp_val.pop_front();
                    ec = exp_cyc.pop_front();
                    if (snap !== ev || cyc != ec) begin
                        failures++;
                        $display("FAIL output_event got=%h at cyc %0d, expected=%h at cyc %0d",
                                 snap, cyc, ev, ec);
                    end
                end
                prev = snap;
            end
        end
    end

    initial begin
        int r;
        int a;
        int w;
        int lc;
        reset_n     = 1'b0;
        pll_locked  = 1'b0;
        clear_fault = 1'b0;

        // Reset state, then lock acquisition and the stability window.
        expect_at(1,  tup(1, 0, 0, 0, 0, 0));
        expect_at(2 + R, tup(0, 0, 0, 0, 0, 0));
        expect_at(23 + S, tup(0, 1, 1, 0, 0, 0));
        to_neg(2);   reset_n = 1'b1;
        to_neg(20);  pll_locked = 1'b1;

        // One-cycle lock dip in RUN: loss three cycles later, full re-lock.
        expect_at(63, tup(1, 0, 0, 0, 0, 1));
        expect_at(63 + R, tup(0, 0, 0, 0, 0, 1));
        expect_at(68 + S, tup(0, 1, 1, 0, 0, 1));
        to_neg(60);  pll_locked = 1'b0;
        to_neg(61);  pll_locked = 1'b1;

        // Loss, then a dip inside STABLE restarts the window without a retry.
        expect_at(113, tup(1, 0, 0, 0, 0, 2));
        expect_at(113 + R, tup(0, 0, 0, 0, 0, 2));
        expect_at(137 + S, tup(0, 1, 1, 0, 0, 2));
        to_neg(110); pll_locked = 1'b0;
        to_neg(120); pll_locked = 1'b1;
        to_neg(133); pll_locked = 1'b0;
        to_neg(134); pll_locked = 1'b1;

        // Lock never returns: four timeouts end in FAULT; an early clear_fault is ignored.
        expect_at(183, tup(1, 0, 0, 0, 0, 3));
        w = 183 + R;
        for (int i = 0; i < 4; i++) begin
            expect_at(w, tup(0, 0, 0, 0, i, 3));
            if (i < 3) expect_at(w + LT, tup(1, 0, 0, 0, i + 1, 3));
            else       expect_at(w + LT, tup(1, 0, 0, 1, 4, 3));
            w = w + LT + R;
        end
        to_neg(180); pll_locked = 1'b0;
        to_neg(200); clear_fault = 1'b1;
        to_neg(201); clear_fault = 1'b0;

        // clear_fault leaves FAULT; lock then returns.
        expect_at(411, tup(1, 0, 0, 0, 0, 3));
        expect_at(411 + R, tup(0, 0, 0, 0, 0, 3));
        expect_at(423 + S, tup(0, 1, 1, 0, 0, 3));
        to_neg(410); clear_fault = 1'b1;
        to_neg(411); clear_fault = 1'b0;
        to_neg(420); pll_locked = 1'b1;

        // Asynchronous reset while running, lock input still high.
        expect_at(471, tup(1, 0, 0, 0, 0, 0));
        expect_at(474 + R, tup(0, 0, 0, 0, 0, 0));
        expect_at(479 + S, tup(0, 1, 1, 0, 0, 0));
        to_neg(470); reset_n = 1'b0;
        to_neg(474); reset_n = 1'b1;

        // 300 losses: the loss counter saturates at 255.
        r = 479 + S;
        for (int k = 1; k <= 300; k++) begin
            a  = r + 2;
            lc = (k > 255) ? 255 : k;
            expect_at(a + 3, tup(1, 0, 0, 0, 0, lc));
            expect_at(a + 3 + R, tup(0, 0, 0, 0, 0, lc));
            expect_at(a + 8 + S, tup(0, 1, 1, 0, 0, lc));
            to_neg(a);     pll_locked = 1'b0;
            to_neg(a + 1); pll_locked = 1'b1;
            r = a + 8 + S;
        end
        to_neg(r + 10);

        while (exp_val.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_event expected=%h at cyc %0d, got nothing by cyc %0d",
                     exp_val[0], exp_cyc[0], cyc);
            void'(exp_val.pop_front());
            void'(exp_cyc.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
